// File: rtl/i2c_slave_rx_if.sv
// Bus and local-side signals of the write-only I2C slave receiver.
// The slave modport is the receiver's view; master is the environment's view.
interface i2c_slave_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       addr_hit;
  logic       busy;
  logic       overrun;

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output sda_oe, rx_data, rx_valid, addr_hit, busy, overrun
  );

  modport master (
    output scl_in, sda_in, rx_ready,
    input  sda_oe, rx_data, rx_valid, addr_hit, busy, overrun
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: oversamples SCL/SDA, decodes START/STOP, matches
// a 7-bit address, ACKs accepted bytes and hands them out on a valid/ready port.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic          clk,
  input  logic          reset,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack;
  logic       ack_drv;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       handshake, addr_match;
  logic [7:0] byte_in;

  // Stage p0/p1: synchronizer; p2: history. Idle-high reset avoids false edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_det  = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
  assign stop_det   = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
  assign handshake  = bus.rx_valid & bus.rx_ready;
  assign byte_in    = {shreg[6:0], sda_p1};
  assign addr_match = (byte_in[7:1] == SLAVE_ADDR) && !byte_in[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      ack          <= 1'b0;
      ack_drv      <= 1'b0;
      bus.sda_oe   <= 1'b0;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      bus.addr_hit <= 1'b0;
      bus.busy     <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      bus.addr_hit <= 1'b0;
      // A load later in this block overrides the handshake clear.
      if (handshake)
        bus.rx_valid <= 1'b0;

      if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= 3'd0;
        shreg       <= 8'h00;
        bus.overrun <= 1'b0;
        bus.sda_oe  <= 1'b0;
        ack_drv     <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        bus.busy   <= 1'b0;
        bus.sda_oe <= 1'b0;
        ack_drv    <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack          <= addr_match;
                bus.addr_hit <= addr_match;
                if (addr_match)
                  bus.busy <= 1'b1;
                state <= ADDR_ACK;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!bus.rx_valid || bus.rx_ready) begin
                  bus.rx_data  <= byte_in;
                  bus.rx_valid <= 1'b1;
                  ack          <= 1'b1;
                end else begin
                  bus.overrun <= 1'b1;
                  ack         <= 1'b0;
                end
                state <= DATA_ACK;
              end
            end
          end
          // First SCL fall drives the ACK slot, the second one ends it.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                bus.sda_oe <= ack;
                ack_drv    <= 1'b1;
              end else begin
                bus.sda_oe <= 1'b0;
                ack_drv    <= 1'b0;
                state      <= ack ? DATA : IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
